// File: rtl/eq_gain_regbank.sv
// eq_gain_regbank
//   Double-buffered equaliser gain register bank. A byte-wide write bus fills
//   a configuration byte and NUM_BANDS shadow gains (GAIN_BYTES each, stored
//   little-endian). After a commit request, the next sample_tick copies every
//   shadow gain into the active gain bus in one edge. The filter therefore
//   never sees a partially written gain.
//
//   Address map (N = NUM_BANDS*GAIN_BYTES):
//     0        configuration
//     1..N     shadow gain bytes, band k byte j at 1+(k-1)*GAIN_BYTES+j
//     N+1      CTRL  (write bit0=1 requests commit, read {7'b0, pending})
//     other    unmapped (addr_err pulse)
//
//   Optional macro EQ_GAIN_REGBANK_AUTOINC_EN:
//     The all-ones address becomes a burst port. Writes to it land at an
//     internal pointer that then advances over 1..N. Any direct write to
//     0..N moves the pointer to addr+1. Reads of the burst port return the
//     byte at the pointer and do not advance it.
//
//   Ports:
//     clk_i            system clock, rising edge
//     rst_i            synchronous active-high reset
//     we_i / re_i      write / read strobes
//     addr_i           byte address
//     data_in_i        write data
//     sample_tick_i    one-cycle sample boundary pulse
//     rd_data_o        registered read data (holds when no read)
//     rd_valid_o       read data valid pulse, one cycle after re_i
//     configuration_o  configuration register
//     gain_bus_o       active gains, band k at [k*GW-1 : (k-1)*GW]
//     commit_pending_o commit requested but not yet applied
//     gains_updated_o  one-cycle pulse after the active gains are loaded
//     addr_err_o       one-cycle pulse after an access to an unmapped address
//
//   FSM states:
//     state     | meaning
//     S_IDLE    | no commit outstanding
//     S_PENDING | commit requested, waiting for the next sample_tick
module eq_gain_regbank #(
  parameter int NUM_BANDS  = 10,
  parameter int GAIN_BYTES = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              we_i,
  input  logic                              re_i,
  input  logic [ADDR_WIDTH-1:0]             addr_i,
  input  logic [7:0]                        data_in_i,
  input  logic                              sample_tick_i,
  output logic [7:0]                        rd_data_o,
  output logic                              rd_valid_o,
  output logic [7:0]                        configuration_o,
  output logic [NUM_BANDS*GAIN_BYTES*8-1:0] gain_bus_o,
  output logic                              commit_pending_o,
  output logic                              gains_updated_o,
  output logic                              addr_err_o
);

  localparam int GW = 8 * GAIN_BYTES;
  localparam int N  = NUM_BANDS * GAIN_BYTES;
  localparam logic [ADDR_WIDTH-1:0] GAIN_LAST = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(N + 1);

  typedef enum logic {S_IDLE, S_PENDING} state_e;

  state_e                  state_q;
  logic [7:0]              config_q;
  logic [7:0]              shadow_q [N];
  logic [7:0]              shadow_d [N];
  logic [N*8-1:0]          shadow_flat_d;
  logic [NUM_BANDS*GW-1:0] active_q;
  logic [7:0]              rd_data_q;
  logic                    rd_valid_q;
  logic                    addr_err_q;
  logic                    commit_pending_q;
  logic                    gains_updated_q;

  logic [ADDR_WIDTH-1:0]   eff_addr;
  logic                    is_cfg;
  logic                    is_gain;
  logic                    is_ctrl;
  logic                    mapped;
  logic                    commit_req;
  logic [7:0]              rd_byte;

`ifdef EQ_GAIN_REGBANK_AUTOINC_EN
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_inc;

  // The burst port is redirected to the pointer. The pointer always lies in
  // 1..N, so every burst access decodes as a shadow gain byte.
  assign eff_addr = (addr_i == '1) ? ptr_q : addr_i;

  // A burst write has eff_addr == ptr_q, so one increment-and-wrap expression
  // serves both burst and direct writes.
  assign ptr_inc = (eff_addr >= GAIN_LAST) ? ADDR_WIDTH'(1)
                                           : eff_addr + ADDR_WIDTH'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= ADDR_WIDTH'(1);
    end else if (we_i && (eff_addr <= GAIN_LAST)) begin
      ptr_q <= ptr_inc;
    end
  end
`else
  assign eff_addr = addr_i;
`endif

  assign is_cfg     = (eff_addr == '0);
  assign is_gain    = (eff_addr >= ADDR_WIDTH'(1)) && (eff_addr <= GAIN_LAST);
  assign is_ctrl    = (eff_addr == CTRL_ADDR);
  assign mapped     = is_cfg | is_gain | is_ctrl;
  assign commit_req = we_i & is_ctrl & data_in_i[0];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      shadow_d[i] = shadow_q[i];
      if (we_i && (eff_addr == ADDR_WIDTH'(i + 1))) begin
        shadow_d[i] = data_in_i;
      end
    end
  end

  // Shadow byte i maps to gain bus bits [8i+7:8i]. This follows from the
  // little-endian, band-major address layout.
  always_comb begin
    shadow_flat_d = '0;
    for (int i = 0; i < N; i++) begin
      shadow_flat_d[i*8 +: 8] = shadow_d[i];
    end
  end

  // Reads sample the pre-edge contents. A same-cycle write to the same
  // address therefore returns the old value.
  always_comb begin
    rd_byte = 8'h00;
    if (is_cfg) begin
      rd_byte = config_q;
    end else if (is_ctrl) begin
      rd_byte = {7'b0, commit_pending_q};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (eff_addr == ADDR_WIDTH'(i + 1)) begin
          rd_byte = shadow_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      config_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      if (we_i && is_cfg) begin
        config_q <= data_in_i;
      end
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      rd_valid_q <= re_i;
      if (re_i) begin
        rd_data_q <= rd_byte;
      end
      addr_err_q <= (we_i | re_i) & ~mapped;
    end
  end

  // The apply path copies shadow_d rather than shadow_q. A shadow write in
  // the same cycle as the applying tick is therefore included in the copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= S_IDLE;
      commit_pending_q <= 1'b0;
      gains_updated_q  <= 1'b0;
      active_q         <= '0;
    end else begin
      gains_updated_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A tick in the same cycle as the commit write is not used.
          if (commit_req) begin
            state_q          <= S_PENDING;
            commit_pending_q <= 1'b1;
          end
        end
        S_PENDING: begin
          // Repeat commits are absorbed here.
          if (sample_tick_i) begin
            active_q         <= shadow_flat_d;
            gains_updated_q  <= 1'b1;
            commit_pending_q <= 1'b0;
            state_q          <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign rd_data_o        = rd_data_q;
  assign rd_valid_o       = rd_valid_q;
  assign configuration_o  = config_q;
  assign gain_bus_o       = active_q;
  assign commit_pending_o = commit_pending_q;
  assign gains_updated_o  = gains_updated_q;
  assign addr_err_o       = addr_err_q;

endmodule

// File: tb/tb_eq_gain_regbank.sv
module tb_eq_gain_regbank;

  localparam int NB   = 10;
  localparam int GB   = 3;
  localparam int AW   = 8;
  localparam int GW   = 8 * GB;
  localparam int N    = NB * GB;
  localparam int CTRL = N + 1;

`ifdef EQ_GAIN_REGBANK_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic              re;
  logic [AW-1:0]     addr;
  logic [7:0]        data_in;
  logic              sample_tick;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic [7:0]        configuration;
  logic [NB*GW-1:0]  gain_bus;
  logic              commit_pending;
  logic              gains_updated;
  logic              addr_err;

  eq_gain_regbank #(.NUM_BANDS(NB), .GAIN_BYTES(GB), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .we_i(we), .re_i(re), .addr_i(addr),
    .data_in_i(data_in), .sample_tick_i(sample_tick),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .configuration_o(configuration), .gain_bus_o(gain_bus),
    .commit_pending_o(commit_pending), .gains_updated_o(gains_updated),
    .addr_err_o(addr_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: byte memory indexed by address, plus a pending flag.
  logic [7:0] m_cfg;
  logic [7:0] m_sh  [0:N];
  logic [7:0] m_act [0:N];
  bit         m_pend;
  int         m_ptr;
  logic [7:0] m_rd;
  bit         m_rv, m_err, m_upd;

  task automatic model_reset();
    m_cfg = 8'h00;
    for (int i = 0; i <= N; i++) begin
      m_sh[i]  = 8'h00;
      m_act[i] = 8'h00;
    end
    m_pend = 1'b0; m_ptr = 1;
    m_rd = 8'h00; m_rv = 1'b0; m_err = 1'b0; m_upd = 1'b0;
  endtask

  task automatic model_step(bit w, bit r, int a, logic [7:0] d, bit t);
    int ea;
    bit commit;
    ea = (AUTOINC && a == (1 << AW) - 1) ? m_ptr : a;
    m_err = (w || r) && (ea > CTRL);
    m_rv  = r;
    if (r) begin
      if (ea == 0)         m_rd = m_cfg;
      else if (ea <= N)    m_rd = m_sh[ea];
      else if (ea == CTRL) m_rd = {7'b0, m_pend};
      else                 m_rd = 8'h00;
    end
    commit = w && (ea == CTRL) && d[0];
    if (w && ea == 0) m_cfg = d;
    if (w && ea >= 1 && ea <= N) m_sh[ea] = d;
    if (AUTOINC && w && ea <= N) m_ptr = (ea + 1 > N) ? 1 : ea + 1;
    if (m_pend && t) begin
      for (int i = 1; i <= N; i++) m_act[i] = m_sh[i];
      m_upd  = 1'b1;
      m_pend = 1'b0;
    end else begin
      m_upd = 1'b0;
      if (commit) m_pend = 1'b1;
    end
  endtask

  function automatic logic [NB*GW-1:0] model_bus();
    logic [NB*GW-1:0] b;
    b = '0;
    for (int i = 1; i <= N; i++) b[(i-1)*8 +: 8] = m_act[i];
    return b;
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("model_rd_data",        256'(rd_data),        256'(m_rd));
    chk("model_rd_valid",       256'(rd_valid),       256'(m_rv));
    chk("model_addr_err",       256'(addr_err),       256'(m_err));
    chk("model_gains_updated",  256'(gains_updated),  256'(m_upd));
    chk("model_commit_pending", 256'(commit_pending), 256'(m_pend));
    chk("model_configuration",  256'(configuration),  256'(m_cfg));
    chk("model_gain_bus",       256'(gain_bus),       256'(model_bus()));
  endtask

  task automatic cycle(bit w, bit r, int a, logic [7:0] d, bit t);
    we = w; re = r; addr = a[AW-1:0]; data_in = d; sample_tick = t;
    @(posedge clk);
    model_step(w, r, a, d, t);
    #1;
    we = 1'b0; re = 1'b0; sample_tick = 1'b0;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0; sample_tick = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    compare_model();
  endtask

  task automatic read_expect(string name, int a, logic [7:0] exp);
    cycle(1'b0, 1'b1, a, 8'h00, 1'b0);
    chk(name, 256'(rd_data), 256'(exp));
  endtask

  typedef struct {
    bit         w, r;
    int         a;
    logic [7:0] d;
    bit         t;
    logic [7:0] x_rd;
    bit         x_rv, x_err, x_pend, x_upd;
    logic [7:0] x_cfg;
    logic [23:0] x_b2, x_b10;
  } vec_t;

  vec_t vt[$];

  task automatic add(bit w, bit r, int a, int d, bit t, int xrd, bit xrv,
                     bit xerr, bit xp, bit xu, int xcfg, int xb2, int xb10);
    vec_t v;
    v.w = w; v.r = r; v.a = a; v.d = d[7:0]; v.t = t;
    v.x_rd = xrd[7:0]; v.x_rv = xrv; v.x_err = xerr; v.x_pend = xp;
    v.x_upd = xu; v.x_cfg = xcfg[7:0]; v.x_b2 = xb2[23:0]; v.x_b10 = xb10[23:0];
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, a;
    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; data_in = '0; sample_tick = 1'b0;
    model_reset();
    do_reset();
    chk("reset_gain_bus", 256'(gain_bus), 256'(0));
    chk("reset_commit_pending", 256'(commit_pending), 256'(0));
    chk("reset_configuration", 256'(configuration), 256'(0));

    for (int i = 0; i <= CTRL; i++) read_expect($sformatf("reset_read_%0d", i), i, 8'h00);

    // w r addr data tick | rd rv err pend upd cfg band2 band10
    add(0,1,0,   'h00,0, 'h00,1,0,0,0,'h00,'h000000,'h000000);
    add(0,1,32,  'h00,0, 'h00,1,1,0,0,'h00,'h000000,'h000000);
    add(1,0,4,   'hC7,0, 'h00,0,0,0,0,'h00,'h000000,'h000000);
    add(1,0,5,   'h71,0, 'h00,0,0,0,0,'h00,'h000000,'h000000);
    add(1,0,6,   'h1C,0, 'h00,0,0,0,0,'h00,'h000000,'h000000);
    add(0,1,5,   'h00,0, 'h71,1,0,0,0,'h00,'h000000,'h000000);
    add(1,0,31,  'h01,0, 'h71,0,0,1,0,'h00,'h000000,'h000000);
    add(0,0,0,   'h00,0, 'h71,0,0,1,0,'h00,'h000000,'h000000);
    add(0,1,31,  'h00,0, 'h01,1,0,1,0,'h00,'h000000,'h000000);
    add(0,0,0,   'h00,1, 'h01,0,0,0,1,'h00,'h1C71C7,'h000000);
    add(0,0,0,   'h00,0, 'h01,0,0,0,0,'h00,'h1C71C7,'h000000);
    add(1,0,31,  'h01,1, 'h01,0,0,1,0,'h00,'h1C71C7,'h000000);
    add(1,0,28,  'hFF,0, 'h01,0,0,1,0,'h00,'h1C71C7,'h000000);
    add(1,0,29,  'hFF,0, 'h01,0,0,1,0,'h00,'h1C71C7,'h000000);
    add(1,0,30,  'hFF,0, 'h01,0,0,1,0,'h00,'h1C71C7,'h000000);
    add(1,0,5,   'hAA,1, 'h01,0,0,0,1,'h00,'h1CAAC7,'hFFFFFF);
    add(1,0,32,  'h55,0, 'h01,0,1,0,0,'h00,'h1CAAC7,'hFFFFFF);
`ifndef EQ_GAIN_REGBANK_AUTOINC_EN
    add(1,0,255, 'h55,0, 'h01,0,1,0,0,'h00,'h1CAAC7,'hFFFFFF);
`endif
    add(1,0,0,   'h5A,0, 'h01,0,0,0,0,'h5A,'h1CAAC7,'hFFFFFF);
    add(0,1,0,   'h00,0, 'h5A,1,0,0,0,'h5A,'h1CAAC7,'hFFFFFF);
    add(0,1,5,   'h00,0, 'hAA,1,0,0,0,'h5A,'h1CAAC7,'hFFFFFF);
    add(1,0,31,  'h03,0, 'hAA,0,0,1,0,'h5A,'h1CAAC7,'hFFFFFF);
    add(1,0,31,  'h01,0, 'hAA,0,0,1,0,'h5A,'h1CAAC7,'hFFFFFF);
    add(1,0,31,  'h00,0, 'hAA,0,0,1,0,'h5A,'h1CAAC7,'hFFFFFF);
    add(0,0,0,   'h00,1, 'hAA,0,0,0,1,'h5A,'h1CAAC7,'hFFFFFF);
    add(0,0,0,   'h00,1, 'hAA,0,0,0,0,'h5A,'h1CAAC7,'hFFFFFF);
    add(1,1,5,   'hBB,0, 'hAA,1,0,0,0,'h5A,'h1CAAC7,'hFFFFFF);
    add(0,1,5,   'h00,0, 'hBB,1,0,0,0,'h5A,'h1CAAC7,'hFFFFFF);
    add(1,0,31,  'h00,0, 'hBB,0,0,0,0,'h5A,'h1CAAC7,'hFFFFFF);
`ifndef EQ_GAIN_REGBANK_AUTOINC_EN
    add(0,1,255, 'h00,0, 'h00,1,1,0,0,'h5A,'h1CAAC7,'hFFFFFF);
`endif

    foreach (vt[i]) begin
      cycle(vt[i].w, vt[i].r, vt[i].a, vt[i].d, vt[i].t);
      chk($sformatf("vec%0d_rd_data", i),  256'(rd_data),        256'(vt[i].x_rd));
      chk($sformatf("vec%0d_rd_valid", i), 256'(rd_valid),       256'(vt[i].x_rv));
      chk($sformatf("vec%0d_addr_err", i), 256'(addr_err),       256'(vt[i].x_err));
      chk($sformatf("vec%0d_pending", i),  256'(commit_pending), 256'(vt[i].x_pend));
      chk($sformatf("vec%0d_updated", i),  256'(gains_updated),  256'(vt[i].x_upd));
      chk($sformatf("vec%0d_config", i),   256'(configuration),  256'(vt[i].x_cfg));
      chk($sformatf("vec%0d_band2", i),    256'(gain_bus[1*GW +: GW]), 256'(vt[i].x_b2));
      chk($sformatf("vec%0d_band10", i),   256'(gain_bus[9*GW +: GW]), 256'(vt[i].x_b10));
    end

    // Reset while a commit is pending.
    cycle(1'b1, 1'b0, 4, 8'h11, 1'b0);
    cycle(1'b1, 1'b0, CTRL, 8'h01, 1'b0);
    chk("pend_before_reset", 256'(commit_pending), 256'(1));
    do_reset();
    chk("pend_after_reset", 256'(commit_pending), 256'(0));
    chk("gain_after_reset", 256'(gain_bus), 256'(0));
    read_expect("shadow_after_reset", 4, 8'h00);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b1);
    chk("no_apply_after_reset", 256'(gains_updated), 256'(0));

`ifdef EQ_GAIN_REGBANK_AUTOINC_EN
    cycle(1'b1, 1'b0, 1, 8'h10, 1'b0);
    cycle(1'b1, 1'b0, 255, 8'hAA, 1'b0);
    cycle(1'b1, 1'b0, 255, 8'hBB, 1'b0);
    cycle(1'b1, 1'b0, 255, 8'hCC, 1'b0);
    read_expect("burst_addr2", 2, 8'hAA);
    read_expect("burst_addr3", 3, 8'hBB);
    read_expect("burst_addr4", 4, 8'hCC);
    read_expect("burst_read_ptr", 255, 8'h00);
    cycle(1'b1, 1'b0, 1, 8'h10, 1'b0);
    read_expect("burst_read_ptr2a", 255, 8'hAA);
    read_expect("burst_read_ptr2b", 255, 8'hAA);
    cycle(1'b1, 1'b0, N - 1, 8'h33, 1'b0);
    cycle(1'b1, 1'b0, 255, 8'h11, 1'b0);
    cycle(1'b1, 1'b0, 255, 8'h22, 1'b0);
    read_expect("burst_wrap_addrN", N, 8'h11);
    read_expect("burst_wrap_addr1", 1, 8'h22);
`endif

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 9);
        if (sel <= 6)      a = $urandom_range(0, CTRL);
        else if (sel == 7) a = $urandom_range(CTRL + 1, 254);
        else if (sel == 8) a = 255;
        else               a = CTRL;
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
              8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
